// File: rtl/key_switch_conditioner_if.sv
// Pushbutton/switch conditioning bus: the raw board inputs going in and the
// clean, clock-synchronous outputs that the game controller consumes.
interface key_switch_conditioner_if #(
    parameter int NUM_KEYS = 3,
    parameter int SW_WIDTH = 18
);
    logic [NUM_KEYS-1:0] key_n;
    logic [SW_WIDTH-1:0] sw_raw;
    logic [NUM_KEYS-1:0] key_pulse;
    logic [NUM_KEYS-1:0] key_level;
    logic [SW_WIDTH-1:0] sw_sync;

    modport master (
        output key_n,
        output sw_raw,
        input  key_pulse,
        input  key_level,
        input  sw_sync
    );

    modport slave (
        input  key_n,
        input  sw_raw,
        output key_pulse,
        output key_level,
        output sw_sync
    );
endinterface

// File: rtl/key_switch_conditioner.sv
// Synchronizes, debounces and edge-detects active-low pushbuttons; slide switches
// get a plain two-flop synchronizer.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// IDLE          | key released and stable
// PRESS_WAIT    | key seen pressed, counting stable pressed samples
// PRESSED       | debounced press; key_level high, pulse already issued
// RELEASE_WAIT  | key seen released, counting stable released samples
module key_switch_conditioner #(
    parameter int NUM_KEYS        = 3,
    parameter int SW_WIDTH        = 18,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    key_switch_conditioner_if.slave  bus
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_PRESSED,
        ST_RELEASE_WAIT
    } state_t;

    logic [NUM_KEYS-1:0] key_meta_q;
    logic [NUM_KEYS-1:0] key_sync_q;
    logic [SW_WIDTH-1:0] sw_meta_q;
    logic [SW_WIDTH-1:0] sw_sync_q;

    // Inversion happens before the first flop so the internal sense is 1 = pressed.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            key_meta_q <= '0;
            key_sync_q <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            key_meta_q <= ~bus.key_n;
            key_sync_q <= key_meta_q;
            sw_meta_q  <= bus.sw_raw;
            sw_sync_q  <= sw_meta_q;
        end
    end

    assign bus.sw_sync = sw_sync_q;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        state_t        state_q;
        logic [CW-1:0] cnt_q;
        logic          pulse_q;
        logic          level_q;
        logic          sp;

        assign sp = key_sync_q[g];

        always_ff @(posedge CLOCK_50 or posedge reset) begin
            if (reset) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
                level_q <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                unique case (state_q)
                    ST_IDLE: begin
                        if (sp) begin
                            state_q <= ST_PRESS_WAIT;
                            cnt_q   <= '0;
                        end
                    end
                    ST_PRESS_WAIT: begin
                        if (!sp) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= ST_PRESSED;
                            cnt_q   <= '0;
                            pulse_q <= 1'b1;
                            level_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_PRESSED: begin
                        if (!sp) begin
                            state_q <= ST_RELEASE_WAIT;
                            cnt_q   <= '0;
                        end
                    end
                    ST_RELEASE_WAIT: begin
                        // A bounce back to pressed resumes PRESSED without a fresh pulse.
                        if (sp) begin
                            state_q <= ST_PRESSED;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                            level_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end
                endcase
            end
        end

        assign bus.key_pulse[g] = pulse_q;
        assign bus.key_level[g] = level_q;
    end

endmodule

// File: tb/tb_key_switch_conditioner.sv
// Directed bench for key_switch_conditioner with DEBOUNCE_CYCLES=4: press
// latency, bounce rejection, simultaneous keys and asynchronous reset.
module tb_key_switch_conditioner;

    localparam int NK = 3;
    localparam int SW = 18;
    localparam int DB = 4;
    localparam int LAT = DB + 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    key_switch_conditioner_if #(.NUM_KEYS(NK), .SW_WIDTH(SW)) bus ();

    key_switch_conditioner #(
        .NUM_KEYS(NK),
        .SW_WIDTH(SW),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .CLOCK_50(clk),
        .reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        bus.key_n  = 3'b000;
        bus.sw_raw = 18'h3FFFF;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.key_pulse !== 3'b000 || bus.key_level !== 3'b000 || bus.sw_sync !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_async: pulse=%b level=%b sw=%h want 0/0/0",
                     bus.key_pulse, bus.key_level, bus.sw_sync);
        end
        settle(3);
        n_checks++;
        if (bus.key_pulse !== 3'b000 || bus.key_level !== 3'b000 || bus.sw_sync !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_held: pulse=%b level=%b sw=%h want 0/0/0",
                     bus.key_pulse, bus.key_level, bus.sw_sync);
        end
        rst = 1'b0;
        // All keys stay held across reset, so each must run a full PRESS_WAIT.
        for (int e = 1; e <= 9; e++) begin
            tick();
            n_checks++;
            if (bus.sw_sync !== ((e >= 2) ? 18'h3FFFF : 18'h0)) begin
                n_fail++;
                $display("FAIL sw_sync_edge%0d: got %h want %h", e, bus.sw_sync,
                         (e >= 2) ? 18'h3FFFF : 18'h0);
            end
            n_checks++;
            if (bus.key_pulse !== ((e == LAT) ? 3'b111 : 3'b000)) begin
                n_fail++;
                $display("FAIL held_thru_reset_pulse_edge%0d: got %b want %b", e,
                         bus.key_pulse, (e == LAT) ? 3'b111 : 3'b000);
            end
        end
        bus.key_n = 3'b111;
        settle(12);
        n_checks++;
        if (bus.key_level !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release_level: got %b want 000", bus.key_level);
        end
    endtask

    task automatic test_clean_press();
        bus.key_n = 3'b110;
        for (int e = 1; e <= 10; e++) begin
            tick();
            n_checks++;
            if (bus.key_pulse !== ((e == LAT) ? 3'b001 : 3'b000)) begin
                n_fail++;
                $display("FAIL press_pulse_edge%0d: got %b want %b", e, bus.key_pulse,
                         (e == LAT) ? 3'b001 : 3'b000);
            end
            n_checks++;
            if (bus.key_level !== ((e >= LAT) ? 3'b001 : 3'b000)) begin
                n_fail++;
                $display("FAIL press_level_edge%0d: got %b want %b", e, bus.key_level,
                         (e >= LAT) ? 3'b001 : 3'b000);
            end
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            n_checks++;
            if (bus.key_pulse !== 3'b000 || bus.key_level !== 3'b001) begin
                n_fail++;
                $display("FAIL press_hold_cycle%0d: pulse=%b level=%b want 000/001", c,
                         bus.key_pulse, bus.key_level);
            end
        end
    endtask

    task automatic test_release_bounce();
        bus.key_n = 3'b111;
        settle(2);
        bus.key_n = 3'b110;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if (bus.key_pulse !== 3'b000 || bus.key_level !== 3'b001) begin
                n_fail++;
                $display("FAIL rel_bounce_cycle%0d: pulse=%b level=%b want 000/001", c,
                         bus.key_pulse, bus.key_level);
            end
        end
        bus.key_n = 3'b111;
        for (int e = 1; e <= 10; e++) begin
            tick();
            n_checks++;
            if (bus.key_level !== ((e < LAT) ? 3'b001 : 3'b000) || bus.key_pulse !== 3'b000) begin
                n_fail++;
                $display("FAIL release_edge%0d: level=%b pulse=%b want %b/000", e,
                         bus.key_level, bus.key_pulse, (e < LAT) ? 3'b001 : 3'b000);
            end
        end
    endtask

    task automatic test_press_bounce();
        logic [NK-1:0] exp_p;
        bus.key_n = 3'b101;
        settle(2);
        n_checks++;
        if (bus.key_pulse !== 3'b000) begin
            n_fail++;
            $display("FAIL bounce_low_pulse: got %b want 000", bus.key_pulse);
        end
        bus.key_n = 3'b111;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (bus.key_pulse !== 3'b000 || bus.key_level !== 3'b000) begin
                n_fail++;
                $display("FAIL bounce_high_cycle%0d: pulse=%b level=%b want 000/000", c,
                         bus.key_pulse, bus.key_level);
            end
        end
        bus.key_n = 3'b101;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp_p = (e == LAT) ? 3'b010 : 3'b000;
            n_checks++;
            if (bus.key_pulse !== exp_p) begin
                n_fail++;
                $display("FAIL bounce_final_edge%0d: got %b want %b", e, bus.key_pulse, exp_p);
            end
        end
        bus.key_n = 3'b111;
        settle(12);
    endtask

    task automatic test_simultaneous();
        logic [NK-1:0] exp_p;
        bus.key_n = 3'b010;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp_p = (e == LAT) ? 3'b101 : 3'b000;
            n_checks++;
            if (bus.key_pulse !== exp_p) begin
                n_fail++;
                $display("FAIL simul_edge%0d: got %b want %b", e, bus.key_pulse, exp_p);
            end
        end
        n_checks++;
        if (bus.key_level !== 3'b101) begin
            n_fail++;
            $display("FAIL simul_level: got %b want 101", bus.key_level);
        end
        bus.key_n = 3'b111;
        settle(12);
    endtask

    task automatic test_reset_mid();
        logic [NK-1:0] exp_p;
        bus.key_n = 3'b110;
        settle(10);
        bus.key_n = 3'b010;
        settle(5);  // key 2 now in PRESS_WAIT with cnt=2
        n_checks++;
        if (bus.key_level !== 3'b001 || bus.sw_sync !== 18'h3FFFF) begin
            n_fail++;
            $display("FAIL mid_pre_reset: level=%b sw=%h want 001/3ffff", bus.key_level, bus.sw_sync);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.key_level !== 3'b000 || bus.key_pulse !== 3'b000 || bus.sw_sync !== 18'h0) begin
            n_fail++;
            $display("FAIL mid_reset_async: level=%b pulse=%b sw=%h want 0/0/0",
                     bus.key_level, bus.key_pulse, bus.sw_sync);
        end
        settle(2);
        rst = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp_p = (e == LAT) ? 3'b101 : 3'b000;
            n_checks++;
            if (bus.key_pulse !== exp_p) begin
                n_fail++;
                $display("FAIL mid_after_reset_edge%0d: got %b want %b", e, bus.key_pulse, exp_p);
            end
        end
        bus.key_n = 3'b111;
        settle(12);
    endtask

    initial begin
        bus.key_n  = 3'b111;
        bus.sw_raw = '0;
        test_reset();
        test_clean_press();
        test_release_bounce();
        test_press_bounce();
        test_simultaneous();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
